fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU. It owns the program counter, drives the byte address into the combinational instruction ROM, and registers the returned word with its PC into the IF/ID pipeline register for decode. Stalls, branch redirects and fetch faults (misaligned or out-of-range PC) are handled here. A small RUN/HALT state machine stops fetch cleanly on a fault instead of feeding X's downstream.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction ROM and registers {pc, instr, valid} into IF/ID. A RUN/HALT
// FSM stops fetch on a misaligned or out-of-range PC so no X reaches decode.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned IMEM_SIZE = 1024,
    parameter logic [31:0] NOP_INSTR = 32'h8B1F03FF
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic [1:0]  fault_code,
    output logic [31:0] fetch_count
);

    typedef enum logic {StRun, StHalt} state_t;

    localparam logic [1:0] FaultNone     = 2'b00;
    localparam logic [1:0] FaultMisalign = 2'b01;
    localparam logic [1:0] FaultRange    = 2'b10;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] count_q, count_d;

    // Fault class of an address; FaultNone means it is fetchable. The +3 is
    // done in 65 bits so addresses near 2^64 cannot wrap into range.
    function automatic logic [1:0] pc_fault(input logic [63:0] pc);
        logic [64:0] last_byte;
        last_byte = {1'b0, pc} + 65'd3;
        if (pc[1:0] != 2'b00) begin
            return FaultMisalign;
        end else if (last_byte >= 65'(IMEM_SIZE)) begin
            return FaultRange;
        end else begin
            return FaultNone;
        end
    endfunction

    logic [1:0] tgt_fault;
    logic [1:0] cur_fault;
    assign tgt_fault = pc_fault(br_target);
    assign cur_fault = pc_fault(pc_q);

    // Next-state: redirect beats stall beats fault check beats normal fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        fault_d      = fault_q;
        count_d      = count_q;

        unique case (state_q)
            StRun: begin
                if (br_taken) begin
                    ifid_pc_d    = 64'd0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    pc_d         = br_target;
                    if (tgt_fault != FaultNone) begin
                        state_d = StHalt;
                        fault_d = tgt_fault;
                    end
                end else if (stall) begin
                    // hold everything
                end else if (cur_fault != FaultNone) begin
                    ifid_pc_d    = 64'd0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    state_d      = StHalt;
                    fault_d      = cur_fault;
                end else begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = imem_instr;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + 64'd4;
                    if (count_q != 32'hFFFF_FFFF) begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
            StHalt: begin
                ifid_pc_d    = 64'd0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                if (br_taken) begin
                    pc_d    = br_target;
                    fault_d = tgt_fault;
                    if (tgt_fault == FaultNone) begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    // State and pipeline registers; reset discards everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 64'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            fault_q      <= FaultNone;
            count_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            fault_q      <= fault_d;
            count_q      <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_pc    = ifid_pc_q;
    assign if_id_instr = ifid_instr_q;
    assign if_id_valid = ifid_valid_q;
    assign halted      = (state_q == StHalt);
    assign fault_code  = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1 KiB behavioural ROM.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h8B1F03FF;

    logic        clk;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic [1:0]  fault_code;
    logic [31:0] fetch_count;

    logic [31:0] rom [256];
    int n_cmp = 0;
    int n_err = 0;

    fetch_stage #(
        .RESET_PC  (64'd0),
        .IMEM_SIZE (1024),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fault_code  (fault_code),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Illegal addresses return a marker word that must never reach IF/ID.
    assign imem_instr = (imem_addr < 64'd1024 && imem_addr[1:0] == 2'b00) ?
                        rom[imem_addr[9:2]] : 32'hDEAD_BEEF;

    function automatic logic [31:0] word_at(input int idx);
        return 32'hA000_0000 + 32'(idx) * 32'h0001_0003;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
    endtask

    task automatic check_ifid(input string tag, input logic [63:0] pc, input int idx);
        check({tag, " pc"}, if_id_pc, pc);
        check({tag, " instr"}, 64'(if_id_instr), 64'(word_at(idx)));
        check({tag, " valid"}, 64'(if_id_valid), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " addr"}, imem_addr, 64'd0);
        check({tag, " valid"}, 64'(if_id_valid), 64'd0);
        check({tag, " instr"}, 64'(if_id_instr), 64'(NOP));
        check({tag, " ifpc"}, if_id_pc, 64'd0);
        check({tag, " halted"}, 64'(halted), 64'd0);
        check({tag, " fault"}, 64'(fault_code), 64'd0);
        check({tag, " count"}, 64'(fetch_count), 64'd0);
    endtask

    initial begin
        logic [63:0] last_pc;
        bit          done;
        for (int i = 0; i < 256; i++) rom[i] = word_at(i);
        reset_n   = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 64'd0;

        // Reset values, then four sequential fetches.
        #12;
        check_reset_vals("rst");
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_ifid($sformatf("seq%0d", i), 64'(i * 4), i);
        end
        check("seq count", 64'(fetch_count), 64'd4);
        check("seq addr", imem_addr, 64'd16);

        // Stall after the second fetch holds PC, IF/ID and the counter.
        do_reset();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall ifpc", if_id_pc, 64'd4);
            check("stall instr", 64'(if_id_instr), 64'(word_at(1)));
            check("stall addr", imem_addr, 64'd8);
            check("stall count", 64'(fetch_count), 64'd2);
        end
        // Redirect wins over stall: PC=8 here.
        br_taken  = 1'b1;
        br_target = 64'h40;
        step();
        br_taken = 1'b0;
        stall    = 1'b0;
        check("br valid", 64'(if_id_valid), 64'd0);
        check("br instr", 64'(if_id_instr), 64'(NOP));
        check("br addr", imem_addr, 64'h40);
        check("br count", 64'(fetch_count), 64'd2);
        step();
        check_ifid("br tgt", 64'h40, 16);
        check("br tgt count", 64'(fetch_count), 64'd3);

        // Release of a stall fetches the held PC next edge.
        do_reset();
        step();
        step();
        stall = 1'b1;
        step();
        stall = 1'b0;
        step();
        check_ifid("release", 64'd8, 2);

        // Run off the end of the ROM from a fresh reset.
        do_reset();
        last_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        done    = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            if (if_id_valid) last_pc = if_id_pc;
            if (halted) done = 1'b1;
        end
        check("end halted", 64'(halted), 64'd1);
        check("end lastpc", last_pc, 64'd1020);
        check("end fault", 64'(fault_code), 64'd2);
        for (int i = 0; i < 3; i++) begin
            check("end valid", 64'(if_id_valid), 64'd0);
            check("end count", 64'(fetch_count), 64'd256);
            check("end addr", imem_addr, 64'd1024);
            stall = 1'b1;
            step();
            stall = 1'b0;
        end
        check("halt stays", 64'(halted), 64'd1);

        // Illegal redirect while halted: misaligned replaces range fault.
        br_taken  = 1'b1;
        br_target = 64'h102;
        step();
        br_taken = 1'b0;
        check("h mis halted", 64'(halted), 64'd1);
        check("h mis fault", 64'(fault_code), 64'd1);
        check("h mis valid", 64'(if_id_valid), 64'd0);
        // Legal redirect leaves HALT and clears the fault on the same edge.
        br_taken  = 1'b1;
        br_target = 64'h100;
        step();
        br_taken = 1'b0;
        check("h ok halted", 64'(halted), 64'd0);
        check("h ok fault", 64'(fault_code), 64'd0);
        check("h ok valid", 64'(if_id_valid), 64'd0);
        check("h ok addr", imem_addr, 64'h100);
        step();
        check_ifid("h ok tgt", 64'h100, 64);
        check("h ok count", 64'(fetch_count), 64'd257);

        // Redirect from RUN to the last legal word, then to an illegal one.
        br_taken  = 1'b1;
        br_target = 64'd1020;
        step();
        br_taken = 1'b0;
        check("edge halted", 64'(halted), 64'd0);
        step();
        check_ifid("edge fetch", 64'd1020, 255);
        br_taken  = 1'b1;
        br_target = 64'd1021;
        step();
        br_taken = 1'b0;
        check("run mis halted", 64'(halted), 64'd1);
        check("run mis fault", 64'(fault_code), 64'd1);

        // Asynchronous reset mid-run, checked between edges.
        do_reset();
        step();
        step();
        check("pre rst addr", imem_addr, 64'd8);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async");
        #2;
        reset_n = 1'b1;
        step();
        check_ifid("resume", 64'd0, 0);
        check("resume count", 64'(fetch_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
